filt_outbuf: RTL and testbench
==============================

# filt_outbuf

Output stage directly downstream of the 15-tap FIR filter. Accepts the filter's 40-bit `pushout`/`y` stream and rounds it to a 24-bit signed sample. The rounding is round-half-up with saturation, applied after a programmable right shift. Results are buffered in a small FIFO that drains under downstream back-pressure. The filter has no stall input, so this block absorbs bursts; loss on overflow is flagged, never silent.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `SHIFT`, 16: arithmetic right shift applied before rounding; 1..38.
- `OW`, 24: output sample width; 2..40.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `pushin`  in  1  input sample valid (driven by filter `pushout`).
- `din`  in  40  signed sample (driven by filter `y`).
- `stopin`  in  1  downstream not ready; no pop while high.
- `pushout`  out  1  `dout` valid and consumed this cycle.
- `dout`  out  OW  signed rounded/saturated sample at FIFO head.
- `level`  out  clog2(DEPTH)+1  current FIFO occupancy.
- `ovf`  out  1  sticky: a sample was dropped because the FIFO was full.
- `sat`  out  1  sticky: a sample was saturated.

## Operation
- **Stage 1 (registered):** on a clock with `pushin`=1:
  - r = (sign-extend41(din) + 2^(SHIFT-1)) >>> SHIFT.
  - If r > 2^(OW-1)-1, r is clamped to max and `sat` is set.
  - If r < -2^(OW-1), r is clamped to min and `sat` is set.
  - The result is registered together with a valid bit. The valid bit equals `pushin` every cycle, so bubbles propagate.
- **Stage 2 (FIFO write):** when the stage-1 valid bit is 1:
  - Write to `mem[wr_ptr]` and increment `wr_ptr` modulo DEPTH.
  - The write is accepted if `level`<DEPTH, or if `level`==DEPTH and a pop occurs the same cycle.
  - Otherwise the sample is discarded, `ovf` is set, and pointers and level are unchanged.
- **Read:**
  - `dout` = `mem[rd_ptr]`, combinational from registered storage (show-ahead).
  - `pushout` = (`level`≠0) & ~`stopin`.
  - When `pushout`=1, `rd_ptr` increments modulo DEPTH at the edge.
- **Level update:** `level` +1 on write-only, −1 on pop-only, unchanged on simultaneous write+pop or on neither.
- **Wrap-around:** pointers wrap silently. Full/empty is decided from `level`, never from pointer equality.
- **Empty:** `pushout`=0; `dout` holds a stale head value that is don't-care but stable.
- **Sticky flags:** `ovf` and `sat` clear only on reset.
- **Reset mid-operation:** FIFO contents are abandoned; the in-flight stage-1 sample is discarded.

## Timing
- **Reset values:** `pushout`=0 (level 0), `level`=0, `ovf`=0, `sat`=0, `dout`=0 (memory zeroed), pointers 0, stage-1 valid 0.
- **Latency:** `pushin` sampled at edge k → stage-1 at k → FIFO write at k+1 → `pushout`=1 in cycle after k+1 if `stopin`=0. Minimum latency is 2 clocks.
- **Throughput:** one sample/cycle sustained with `stopin`=0. `level` never exceeds 1 in that mode.
- **`stopin` timing:** `stopin` is combinational to `pushout` in the same cycle. There is no registered skid.
- **Full plus pop:** at `level`==DEPTH, a write with simultaneous pop is accepted, so no drop occurs.
- **Full without pop:** a write at `level`==DEPTH with no pop drops exactly that sample. `ovf` rises the following cycle.
- **Flag update:** `sat` rises the cycle after the saturating input is sampled, i.e. when stage 1 registers.

## Test plan
- **Rounding (SHIFT=16, OW=24):**
  - din=98304 → `dout`=2, two clocks after `pushin`.
  - din=-98304 → `dout`=-1.
  - din=32767 → 0; din=32768 → 1.
  - `sat`=0 throughout.
- **Saturation and exact boundary:**
  - din=2^39-1 → `dout`=0x7FFFFF and `sat`=1.
  - After reset, din=-2^39 → `dout`=0x800000 and `sat` stays 0.
- **Streaming:** 100 consecutive samples with `stopin`=0 → in-order output, 2-cycle latency, `level`≤1, no `ovf`.
- **Back-pressure and overflow:**
  - Hold `stopin`=1 and push 10 samples (values 1..10 after rounding) → `level` reaches 8.
  - Samples 9 and 10 are dropped and `ovf`=1.
  - Release `stopin` → outputs 1..8 on 8 consecutive cycles; `level` returns to 0.
- **Full plus simultaneous pop:** fill to 8, then push one sample while dropping `stopin` for one cycle → `level` stays 8, no `ovf`, order preserved across pointer wrap.
- **Reset mid-burst:** assert `reset` low with `level`=5 → `pushout`, `level`, `ovf` and `sat` all go to 0 immediately (asynchronously). The first post-reset sample appears after exactly 2 clocks.

Source files
------------

// File: rtl/filt_outbuf.sv
// filt_outbuf: round/saturate the 40-bit FIR output to OW bits and buffer it in a show-ahead FIFO
// ports: clk; reset (async, active-low); pushin/din sample in; stopin downstream not ready;
//        pushout/dout sample out (consumed when pushout=1); level occupancy; ovf/sat sticky flags
module filt_outbuf #(
  parameter int DEPTH = 8,
  parameter int SHIFT = 16,
  parameter int OW = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pushin,
  input  logic [39:0]              din,
  input  logic                     stopin,
  output logic                     pushout,
  output logic [OW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     sat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic signed [40:0] HALF = 41'sd1 <<< (SHIFT-1);
  localparam logic signed [40:0] MAXV = (41'sd1 <<< (OW-1)) - 41'sd1;
  localparam logic signed [40:0] MINV = -(41'sd1 <<< (OW-1));
  logic signed [40:0] r;
  logic hi, lo, s1_v, wr;
  logic [OW-1:0] res, s1_d;
  logic [OW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_comb begin
    r = ($signed({din[39], din}) + HALF) >>> SHIFT;
    hi = r > MAXV;
    lo = r < MINV;
    res = hi ? {1'b0, {(OW-1){1'b1}}} : lo ? {1'b1, {(OW-1){1'b0}}} : r[OW-1:0];
  end
  // a write into a full FIFO is still accepted when the head leaves in the same cycle
  assign pushout = |level & ~stopin;
  assign wr = s1_v & ((level != FULL) | pushout);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v <= 1'b0;
      s1_d <= '0;
      sat <= 1'b0;
      ovf <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      s1_v <= pushin;
      if (pushin) s1_d <= res;
      if (pushin & (hi | lo)) sat <= 1'b1;
      if (s1_v & ~wr) ovf <= 1'b1;
      if (wr) begin
        mem[wr_ptr] <= s1_d;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pushout) rd_ptr <= rd_ptr + 1'b1;
      level <= (wr & ~pushout) ? level + 1'b1 : (~wr & pushout) ? level - 1'b1 : level;
    end
  end
endmodule

// File: tb/tb_filt_outbuf.sv
// tb_filt_outbuf: randomized and directed checks of filt_outbuf against a queue-based reference model
module tb_filt_outbuf;
  localparam int DEPTH = 8;
  localparam int SHIFT = 16;
  localparam int OW = 24;
  localparam longint HI = (longint'(1) << (OW-1)) - 1;
  localparam longint LO = -(longint'(1) << (OW-1));
  logic clk = 1'b0, reset = 1'b0, pushin = 1'b0, stopin = 1'b0;
  logic [39:0] din = '0;
  logic pushout, ovf, sat;
  logic [OW-1:0] dout;
  logic [3:0] level;
  int n_chk = 0, n_fail = 0;
  logic [OW-1:0] q[$];
  bit m_s1v, m_ovf, m_sat;
  logic [OW-1:0] m_s1d;

  filt_outbuf #(.DEPTH(DEPTH), .SHIFT(SHIFT), .OW(OW)) dut (
    .clk(clk), .reset(reset), .pushin(pushin), .din(din), .stopin(stopin),
    .pushout(pushout), .dout(dout), .level(level), .ovf(ovf), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint rnd(input logic [39:0] d);
    return (longint'($signed(d)) + (longint'(1) << (SHIFT-1))) >>> SHIFT;
  endfunction

  function automatic logic [OW-1:0] expect_out(input logic [39:0] d);
    longint x;
    x = rnd(d);
    if (x > HI) x = HI;
    else if (x < LO) x = LO;
    return x[OW-1:0];
  endfunction

  function automatic bit is_sat(input logic [39:0] d);
    return rnd(d) > HI || rnd(d) < LO;
  endfunction

  task automatic model_reset;
    q.delete();
    m_s1v = 0;
    m_ovf = 0;
    m_sat = 0;
  endtask

  // starts and ends at a falling edge; checks outputs, then advances the model by one clock
  task automatic cycle(input bit p, input logic [39:0] d, input bit s);
    bit pop, acc;
    pushin = p;
    din = d;
    stopin = s;
    #1;
    pop = q.size() != 0 && !s;
    chk("pushout", pushout, pop);
    chk("level", level, q.size());
    chk("ovf", ovf, m_ovf);
    chk("sat", sat, m_sat);
    if (q.size() != 0) chk("dout", dout, q[0]);
    acc = m_s1v && (q.size() < DEPTH || pop);
    if (m_s1v && !acc) m_ovf = 1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(m_s1d);
    m_s1v = p;
    m_s1d = expect_out(d);
    if (p && is_sat(d)) m_sat = 1;
    @(negedge clk);
  endtask

  // one sample, then require it at the head exactly two clocks later
  task automatic dir(input logic [39:0] d, input logic [OW-1:0] exp);
    cycle(1, d, 0);
    cycle(0, '0, 0);
    #1;
    chk("lat2_pushout", pushout, 1);
    chk("lat2_dout", dout, exp);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_pushout", pushout, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sat", sat, 0);
    chk("rst_dout", dout, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] r64;
    logic [39:0] d;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("init_pushout", pushout, 0);
    chk("init_level", level, 0);
    chk("init_ovf", ovf, 0);
    chk("init_sat", sat, 0);
    chk("init_dout", dout, 0);
    reset = 1'b1;
    @(negedge clk);
    dir(40'd98304, 24'd2);
    dir(-40'sd98304, 24'hFFFFFF);
    dir(40'd32767, 24'd0);
    dir(40'd32768, 24'd1);
    chk("round_sat0", sat, 0);
    dir(40'h7F_FFFF_FFFF, 24'h7FFFFF);
    chk("sat_max", sat, 1);
    do_reset();
    dir(40'h80_0000_0000, 24'h800000);
    chk("sat_min_exact", sat, 0);
    for (int i = 0; i < 100; i++) begin
      r64 = {$urandom, $urandom};
      d = r64[39:0];
      d = $signed(d) >>> $urandom_range(0, 24);
      cycle(1, d, 0);
      chk("stream_level_le1", level <= 1, 1);
    end
    repeat (3) cycle(0, '0, 0);
    chk("stream_no_ovf", ovf, 0);
    for (int k = 11; k <= 18; k++) cycle(1, 40'(k << 16), 1);
    cycle(0, '0, 1);
    chk("fill_level", level, 8);
    cycle(1, 40'(19 << 16), 1);
    cycle(0, '0, 0);
    chk("fullpop_level", level, 8);
    chk("fullpop_ovf", ovf, 0);
    repeat (10) cycle(0, '0, 0);
    chk("fullpop_drained", level, 0);
    for (int k = 1; k <= 10; k++) cycle(1, 40'(k << 16), 1);
    cycle(0, '0, 1);
    cycle(0, '0, 1);
    chk("ovf_level", level, 8);
    chk("ovf_set", ovf, 1);
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("drain_seq", dout, k);
      cycle(0, '0, 0);
    end
    chk("drain_level", level, 0);
    cycle(1, 40'h7F_FFFF_FFFF, 1);
    for (int k = 2; k <= 5; k++) cycle(1, 40'(k << 16), 1);
    cycle(0, '0, 1);
    chk("burst_level", level, 5);
    chk("burst_sat", sat, 1);
    do_reset();
    cycle(1, 40'(7 << 16), 0);
    #1;
    chk("post_rst_lat1", pushout, 0);
    cycle(0, '0, 0);
    #1;
    chk("post_rst_lat2_pushout", pushout, 1);
    chk("post_rst_lat2_dout", dout, 7);
    repeat (3) cycle(0, '0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
